// File: rtl/sensor_pkg.sv
// Shared types and defaults for the sensor clock generator.
// Half-period defaults assume a 1 GHz system clock.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Output-frequency scaling selections of the sensor.
    typedef enum logic [1:0] {
        FS_MODE_0 = 2'd0,
        FS_MODE_1 = 2'd1,
        FS_MODE_2 = 2'd2,
        FS_MODE_3 = 2'd3
    } fs_mode_t;

    localparam int DIV_W_DEF = 16;
    localparam int HALF0_DEF = 5000;
    localparam int HALF1_DEF = 1250;
    localparam int HALF2_DEF = 500;
    localparam int HALF3_DEF = 147;

endpackage

// File: rtl/div_counter.sv
// Half-period counter with clear and terminal-count compare.
// half_act is never 0, so the compare never underflows.
module div_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] half_act,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    assign tc = (cnt == half_act - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/clk_divider_mode.sv
// Sensor output-frequency clock divider with four modes.
// Mode and enable changes only act on period boundaries.
module clk_divider_mode
    import sensor_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int HALF0 = HALF0_DEF,
    parameter int HALF1 = HALF1_DEF,
    parameter int HALF2 = HALF2_DEF,
    parameter int HALF3 = HALF3_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    output logic       clk_out,
    output logic       tick_o,
    output logic [1:0] mode_o,
    output logic       busy_o
);

    if (HALF0 >= (1 << DIV_W) || HALF1 >= (1 << DIV_W) ||
        HALF2 >= (1 << DIV_W) || HALF3 >= (1 << DIV_W)) begin : g_bad_half
        $error("clk_divider_mode: HALFn does not fit in DIV_W bits");
    end

    // A zero half-period would never reach terminal count; run it as 1.
    localparam logic [DIV_W-1:0] H0 = (HALF0 == 0) ? DIV_W'(1) : DIV_W'(HALF0);
    localparam logic [DIV_W-1:0] H1 = (HALF1 == 0) ? DIV_W'(1) : DIV_W'(HALF1);
    localparam logic [DIV_W-1:0] H2 = (HALF2 == 0) ? DIV_W'(1) : DIV_W'(HALF2);
    localparam logic [DIV_W-1:0] H3 = (HALF3 == 0) ? DIV_W'(1) : DIV_W'(HALF3);

    state_t           state;
    logic [DIV_W-1:0] half_act;
    logic [DIV_W-1:0] half_sel;
    logic             tc;
    logic             cnt_clr;

    always_comb begin
        half_sel = H0;
        unique case (fs_mode_t'(mode_i))
            FS_MODE_0: half_sel = H0;
            FS_MODE_1: half_sel = H1;
            FS_MODE_2: half_sel = H2;
            FS_MODE_3: half_sel = H3;
        endcase
    end

    assign cnt_clr = (state == IDLE) || tc;

    div_counter #(
        .DIV_W    (DIV_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .half_act (half_act),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clk_out  <= 1'b0;
            tick_o   <= 1'b0;
            mode_o   <= 2'd0;
            busy_o   <= 1'b0;
            half_act <= DIV_W'(1);
        end else begin
            tick_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en_i) begin
                        state    <= HIGH;
                        clk_out  <= 1'b1;
                        tick_o   <= 1'b1;
                        busy_o   <= 1'b1;
                        mode_o   <= mode_i;
                        half_act <= half_sel;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        state   <= LOW;
                        clk_out <= 1'b0;
                    end
                end
                LOW: begin
                    if (tc && en_i) begin
                        state    <= HIGH;
                        clk_out  <= 1'b1;
                        tick_o   <= 1'b1;
                        mode_o   <= mode_i;
                        half_act <= half_sel;
                    end else if (tc) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_out <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_divider_mode.sv
// Directed bench for clk_divider_mode with small half-periods.
// Table of per-cycle vectors plus a hand-written async reset sequence.
module tb_clk_divider_mode;

    logic       clk;
    logic       rst_n;
    logic       en_i;
    logic [1:0] mode_i;
    logic       clk_out;
    logic       tick_o;
    logic [1:0] mode_o;
    logic       busy_o;

    int checks;
    int errors;

    clk_divider_mode #(
        .DIV_W   (4),
        .HALF0   (4),
        .HALF1   (3),
        .HALF2   (2),
        .HALF3   (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en_i),
        .mode_i  (mode_i),
        .clk_out (clk_out),
        .tick_o  (tick_o),
        .mode_o  (mode_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       c;
        logic       t;
        logic [1:0] mo;
        logic       b;
    } vec_t;

    vec_t vecs[64];
    int   nv;

    // Expected outputs are those seen this cycle; en/mode are then driven.
    task automatic add(input logic en, input logic [1:0] m,
                       input logic c, input logic t,
                       input logic [1:0] mo, input logic b);
        vecs[nv].en   = en;
        vecs[nv].mode = m;
        vecs[nv].c    = c;
        vecs[nv].t    = t;
        vecs[nv].mo   = mo;
        vecs[nv].b    = b;
        nv++;
    endtask

    task automatic chk(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {clk,tick,mode,busy}=%b want %b",
                     name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {clk_out, tick_o, mode_o, busy_o};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        nv     = 0;
        rst_n  = 1'b0;
        en_i   = 1'b0;
        mode_i = 2'd0;

        // mode 0 start and steady state
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 1);
        // mode 2 requested mid-HIGH
        add(1, 2, 1, 0, 0, 1);
        add(1, 2, 1, 0, 0, 1);
        add(1, 2, 1, 0, 0, 1);
        add(1, 2, 0, 0, 0, 1);
        add(1, 2, 0, 0, 0, 1);
        add(1, 2, 0, 0, 0, 1);
        add(1, 2, 0, 0, 0, 1);
        add(1, 2, 1, 1, 2, 1);
        add(1, 2, 1, 0, 2, 1);
        add(1, 2, 0, 0, 2, 1);
        add(1, 2, 0, 0, 2, 1);
        // mode 3 continuous
        add(1, 3, 1, 1, 2, 1);
        add(1, 3, 1, 0, 2, 1);
        add(1, 3, 0, 0, 2, 1);
        add(1, 3, 0, 0, 2, 1);
        add(1, 3, 1, 1, 3, 1);
        add(1, 3, 0, 0, 3, 1);
        add(1, 3, 1, 1, 3, 1);
        add(1, 3, 0, 0, 3, 1);
        add(1, 3, 1, 1, 3, 1);
        // mode 1, en dropped during HIGH
        add(1, 1, 0, 0, 3, 1);
        add(1, 1, 1, 1, 1, 1);
        add(0, 1, 1, 0, 1, 1);
        add(0, 1, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0);
        // restart in mode 1, switch to 3 on LOW terminal count
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 1, 1, 1);
        add(1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 1, 1);
        add(1, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, 1, 1);
        add(1, 3, 0, 0, 1, 1);
        add(1, 3, 1, 1, 3, 1);
        add(1, 3, 0, 0, 3, 1);
        add(0, 3, 1, 1, 3, 1);
        add(0, 3, 0, 0, 3, 1);
        add(0, 3, 0, 0, 3, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                {vecs[i].c, vecs[i].t, vecs[i].mo, vecs[i].b});
            en_i   = vecs[i].en;
            mode_i = vecs[i].mode;
        end

        // async reset mid-LOW in mode 0
        @(negedge clk);
        en_i   = 1'b1;
        mode_i = 2'd0;
        repeat (6) @(negedge clk);
        chk("pre_reset_low", outs(), 5'b0_0_00_1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 5'b0_0_00_0);
        @(negedge clk);
        chk("held_reset", outs(), 5'b0_0_00_0);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("restart%0d", k), outs(),
                {(k <= 4 || k == 9), (k == 1 || k == 9), 2'd0, 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
